// File: rtl/polirv_pkg.sv
// Shared definitions for the polirv RV64I core: opcodes, ALU command codes,
// ALU flag bit positions, branch funct3 codes and instruction-class decode.
package polirv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_R  = 4'b0000;
    localparam logic [3:0] ALU_I  = 4'b0001;
    localparam logic [3:0] ALU_S  = 4'b0010;
    localparam logic [3:0] ALU_SB = 4'b0011;
    localparam logic [3:0] ALU_U  = 4'b0100;
    localparam logic [3:0] ALU_UJ = 4'b0101;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_MSB  = 1;
    localparam int FLAG_OVF  = 2;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_LUI,
        CLS_JAL,
        CLS_ILLEGAL
    } instr_class_t;

    // Maps a raw opcode onto the instruction class the control unit sequences.
    function automatic instr_class_t decode_class(input logic [6:0] op);
        instr_class_t c;
        case (op)
            OP_R:      c = CLS_R;
            OP_I_ALU:  c = CLS_I_ALU;
            OP_LOAD:   c = CLS_LOAD;
            OP_STORE:  c = CLS_STORE;
            OP_BRANCH: c = CLS_BRANCH;
            OP_LUI:    c = CLS_LUI;
            OP_JAL:    c = CLS_JAL;
            default:   c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    // ALU command the datapath needs for each class.
    function automatic logic [3:0] class_alu_cmd(input instr_class_t c);
        logic [3:0] cmd;
        case (c)
            CLS_I_ALU, CLS_LOAD: cmd = ALU_I;
            CLS_STORE:           cmd = ALU_S;
            CLS_BRANCH:          cmd = ALU_SB;
            CLS_LUI:             cmd = ALU_U;
            CLS_JAL:             cmd = ALU_UJ;
            default:             cmd = ALU_R;
        endcase
        return cmd;
    endfunction

    // Second ALU operand: register file (0) or immediate (1).
    function automatic logic class_alu_src(input instr_class_t c);
        return !(c == CLS_R || c == CLS_BRANCH || c == CLS_ILLEGAL);
    endfunction

endpackage

// File: rtl/uc_branch_eval.sv
// Branch condition evaluation from ALU flags after the compare subtraction.
// Signed less-than is MSB xor overflow; unsupported funct3 never branches.
module uc_branch_eval
    import polirv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [3:0] alu_flags,
    output logic       taken
);

    logic lt;
    logic unused_flag;

    assign lt          = alu_flags[FLAG_MSB] ^ alu_flags[FLAG_OVF];
    assign unused_flag = alu_flags[3];

    // Select the branch condition that matches funct3.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = alu_flags[FLAG_ZERO];
            F3_BNE:  taken = !alu_flags[FLAG_ZERO];
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit for polirv: sequences fd through
// FETCH/DECODE/EXEC/MEM/WB, waits on data memory with a timeout and
// halts on illegal opcodes or memory timeout.
module uc_multiciclo
    import polirv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_BITS       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [3:0] alu_flags,
    input  logic       d_mem_ready,
    output logic       ir_we,
    output logic       pc_we,
    output logic       d_mem_we,
    output logic       rf_we,
    output logic [3:0] alu_cmd,
    output logic       alu_src,
    output logic       pc_src,
    output logic       rf_src,
    output logic       halted,
    output logic       err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

    logic [2:0]          state;
    logic [2:0]          next_state;
    instr_class_t        cls;
    instr_class_t        dec_cls;
    logic [CNT_BITS-1:0] wait_cnt;
    logic                err_q;
    logic                taken;
    logic                timeout;

    assign dec_cls = decode_class(opcode);
    assign timeout = (state == S_MEM) && !d_mem_ready && (wait_cnt == CNT_LAST);

    uc_branch_eval u_branch_eval (
        .funct3    (funct3),
        .alu_flags (alu_flags),
        .taken     (taken)
    );

    // Next-state selection for the instruction sequence.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: next_state = (dec_cls == CLS_ILLEGAL) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (cls)
                    CLS_LOAD, CLS_STORE: next_state = S_MEM;
                    CLS_BRANCH:          next_state = S_FETCH;
                    default:             next_state = S_WB;
                endcase
            end
            S_MEM: begin
                if (d_mem_ready)
                    next_state = (cls == CLS_STORE) ? S_FETCH : S_WB;
                else if (timeout)
                    next_state = S_HALT;
            end
            S_WB:     next_state = S_FETCH;
            default:  next_state = S_HALT;
        endcase
    end

    // State register plus the instruction class captured while the opcode is decoded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cls   <= CLS_R;
        end else begin
            state <= next_state;
            if (state == S_DECODE)
                cls <= dec_cls;
        end
    end

    // Memory wait counter: cleared on entry to MEM, counts cycles without ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state == S_EXEC)
            wait_cnt <= '0;
        else if (state == S_MEM && !d_mem_ready && wait_cnt != CNT_LAST)
            wait_cnt <= wait_cnt + CNT_BITS'(1);
    end

    // Sticky timeout error, only cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (timeout)
            err_q <= 1'b1;
    end

    // Datapath controls decoded from the current state and instruction class.
    always_comb begin
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        d_mem_we = 1'b0;
        rf_we    = 1'b0;
        alu_cmd  = ALU_R;
        alu_src  = 1'b0;
        pc_src   = 1'b0;
        rf_src   = 1'b0;
        halted   = 1'b0;
        case (state)
            S_FETCH: ir_we = 1'b1;
            S_EXEC: begin
                alu_cmd = class_alu_cmd(cls);
                alu_src = class_alu_src(cls);
                if (cls == CLS_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_src = taken;
                end
            end
            S_MEM: begin
                alu_cmd  = class_alu_cmd(cls);
                alu_src  = class_alu_src(cls);
                d_mem_we = (cls == CLS_STORE);
                pc_we    = (cls == CLS_STORE) && d_mem_ready;
            end
            S_WB: begin
                alu_cmd = class_alu_cmd(cls);
                alu_src = class_alu_src(cls);
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                rf_src  = (cls == CLS_LOAD);
                pc_src  = (cls == CLS_JAL);
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo: a per-instruction reference model
// builds the expected cycle-by-cycle control pattern, a vector table checks
// latency and per-class controls, and random instructions follow.
module tb_uc_multiciclo;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [3:0] alu_flags = '0;
    logic       d_mem_ready = 1'b0;
    logic       ir_we, pc_we, d_mem_we, rf_we;
    logic [3:0] alu_cmd;
    logic       alu_src, pc_src, rf_src, halted, err;

    always #5 clk = ~clk;

    uc_multiciclo #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_BITS(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .alu_flags(alu_flags), .d_mem_ready(d_mem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .d_mem_we(d_mem_we), .rf_we(rf_we),
        .alu_cmd(alu_cmd), .alu_src(alu_src), .pc_src(pc_src), .rf_src(rf_src),
        .halted(halted), .err(err)
    );

    // {ir_we, pc_we, d_mem_we, rf_we, alu_cmd[3:0], alu_src, pc_src, rf_src, halted, err}
    logic [12:0] outv;
    assign outv = {ir_we, pc_we, d_mem_we, rf_we, alu_cmd, alu_src, pc_src, rf_src, halted, err};

    localparam logic [12:0] CARE_BASE = 13'b1111_0000_0_0_0_1_1;
    localparam logic [12:0] CARE_ALU  = 13'b0000_1111_1_0_0_0_0;
    localparam logic [12:0] CARE_PSRC = 13'b0000_0000_0_1_0_0_0;
    localparam logic [12:0] CARE_RSRC = 13'b0000_0000_0_0_1_0_0;
    localparam logic [12:0] CARE_ALL  = 13'h1fff;
    localparam logic [12:0] V_FETCH   = 13'b1000_0000_0_0_0_0_0;
    localparam logic [12:0] V_HALT    = 13'b0000_0000_0_0_0_1_0;
    localparam logic [12:0] V_HALTERR = 13'b0000_0000_0_0_0_1_1;

    typedef struct {
        logic        rdy;
        logic [12:0] exp;
        logic [12:0] care;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [3:0] fl;
        int         waits;
        int         hold;
        int         len;
        logic [3:0] cmd;
        logic       asrc;
        logic       psrc;
        logic       rfwe;
        logic       rsrc;
        int         dwe;
        logic       halt;
        logic       errx;
    } vec_t;

    cyc_t expQ[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;

    int         obsLen, obsDwe;
    logic [3:0] obsCmd;
    logic       obsAsrc, obsPsrc, obsRfWe, obsRsrc, obsHalt, obsErr;

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    function automatic logic [12:0] mk(input logic pc, input logic dwe, input logic rfwe,
                                       input logic [3:0] cmd, input logic asrc,
                                       input logic psrc, input logic rsrc);
        return {1'b0, pc, dwe, rfwe, cmd, asrc, psrc, rsrc, 1'b0, 1'b0};
    endfunction

    task automatic pushCyc(input logic rdy, input logic [12:0] e, input logic [12:0] c);
        cyc_t r;
        r.rdy = rdy;
        r.exp = e;
        r.care = c;
        expQ.push_back(r);
    endtask

    // Reference model: expected control pattern for one whole instruction.
    task automatic buildSeq(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] fl,
                            input int waits, input int hold);
        logic legal, isLoad, isStore, isBranch, isJal, taken, lt, rdy;
        logic [3:0] cmd;
        logic asrc;
        legal = 1'b1; isLoad = 1'b0; isStore = 1'b0; isBranch = 1'b0; isJal = 1'b0;
        cmd = 4'd0; asrc = 1'b0;
        case (op)
            7'b0110011: begin cmd = 4'd0; asrc = 1'b0; end
            7'b0010011: begin cmd = 4'd1; asrc = 1'b1; end
            7'b0000011: begin cmd = 4'd1; asrc = 1'b1; isLoad = 1'b1; end
            7'b0100011: begin cmd = 4'd2; asrc = 1'b1; isStore = 1'b1; end
            7'b1100011: begin cmd = 4'd3; asrc = 1'b0; isBranch = 1'b1; end
            7'b0110111: begin cmd = 4'd4; asrc = 1'b1; end
            7'b1101111: begin cmd = 4'd5; asrc = 1'b1; isJal = 1'b1; end
            default:    legal = 1'b0;
        endcase
        lt = fl[1] ^ fl[2];
        case (f3)
            3'b000:  taken = fl[0];
            3'b001:  taken = !fl[0];
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            default: taken = 1'b0;
        endcase
        expQ.delete();
        pushCyc(rnd(), V_FETCH, CARE_BASE);
        pushCyc(rnd(), 13'd0, CARE_BASE);
        if (!legal) begin
            for (int i = 0; i < hold; i++) pushCyc(rnd(), V_HALT, CARE_BASE);
            return;
        end
        if (isBranch) begin
            pushCyc(rnd(), mk(1'b1, 1'b0, 1'b0, cmd, asrc, taken, 1'b0), CARE_BASE | CARE_ALU | CARE_PSRC);
            return;
        end
        pushCyc(rnd(), mk(1'b0, 1'b0, 1'b0, cmd, asrc, 1'b0, 1'b0), CARE_BASE | CARE_ALU);
        if (isLoad || isStore) begin
            for (int i = 0; i < TIMEOUT; i++) begin
                rdy = (i == waits);
                if (rdy && isStore)
                    pushCyc(1'b1, mk(1'b1, 1'b1, 1'b0, cmd, asrc, 1'b0, 1'b0), CARE_BASE | CARE_ALU | CARE_PSRC);
                else
                    pushCyc(rdy, mk(1'b0, isStore, 1'b0, cmd, asrc, 1'b0, 1'b0), CARE_BASE | CARE_ALU);
                if (rdy) break;
            end
            if (waits >= TIMEOUT) begin
                for (int i = 0; i < hold; i++) pushCyc(rnd(), V_HALTERR, CARE_BASE);
                return;
            end
            if (isStore) return;
        end
        pushCyc(rnd(), mk(1'b1, 1'b0, 1'b1, cmd, asrc, isJal, isLoad), CARE_BASE | CARE_ALU | CARE_PSRC | CARE_RSRC);
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [3:0] fl, input logic rdy);
        opcode = op;
        funct3 = f3;
        alu_flags = fl;
        d_mem_ready = rdy;
    endtask

    task automatic checkOutput(input string name, input logic [12:0] e, input logic [12:0] c);
        total++;
        if ((outv & c) !== (e & c)) begin
            bad++;
            $display("[TB] FAIL %s got=%b want=%b care=%b t=%0t", name, outv, e, c, $time);
        end
    endtask

    task automatic checkVal(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
        end
    endtask

    // Runs up to maxc cycles of one instruction, checking every cycle against the model.
    task automatic runInstr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic [3:0] fl, input int waits, input int hold, input int maxc);
        buildSeq(op, f3, fl, waits, hold);
        obsLen = 0; obsDwe = 0; obsCmd = 4'hf; obsAsrc = 1'b0; obsPsrc = 1'b0;
        obsRfWe = 1'b0; obsRsrc = 1'b0; obsHalt = 1'b0; obsErr = 1'b0;
        for (int i = 0; i < expQ.size() && i < maxc; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(op, f3, fl, expQ[i].rdy);
            #3;
            checkOutput($sformatf("%s c%0d", tag, i), expQ[i].exp, expQ[i].care);
            if (i == 2) begin obsCmd = alu_cmd; obsAsrc = alu_src; end
            if (pc_we) begin obsLen = i + 1; obsPsrc = pc_src; end
            if (rf_we) begin obsRfWe = 1'b1; obsRsrc = rf_src; end
            if (d_mem_we) obsDwe++;
            obsHalt = halted;
            obsErr = err;
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 rst = 1'b1;
        #2 checkOutput("reset_async", 13'd0, CARE_ALL);
        @(posedge clk);
        #1 rst = 1'b0;
        #3 checkOutput("reset_idle", 13'd0, CARE_ALL);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t v;
        logic [6:0] legalOps[7];
        logic [6:0] op;
        int waits;

        // op, f3, flags, waits, hold | len, cmd, asrc, psrc, rfwe, rsrc, dwe, halt, err
        vecs.push_back('{7'b0110011, 3'b000, 4'b0000, 0, 0, 4, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0});
        vecs.push_back('{7'b0010011, 3'b111, 4'b1111, 0, 0, 4, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0});
        vecs.push_back('{7'b0110111, 3'b000, 4'b0000, 0, 0, 4, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0});
        vecs.push_back('{7'b1101111, 3'b000, 4'b0000, 0, 0, 4, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0});
        vecs.push_back('{7'b1100011, 3'b000, 4'b0001, 0, 0, 3, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0});
        vecs.push_back('{7'b1100011, 3'b100, 4'b0110, 0, 0, 3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0});
        vecs.push_back('{7'b1100011, 3'b001, 4'b0000, 0, 0, 3, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0});
        vecs.push_back('{7'b1100011, 3'b101, 4'b0010, 0, 0, 3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0});
        vecs.push_back('{7'b1100011, 3'b010, 4'b1111, 0, 0, 3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0});
        vecs.push_back('{7'b0000011, 3'b011, 4'b0000, 3, 0, 8, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0});
        vecs.push_back('{7'b0000011, 3'b011, 4'b0000, 0, 0, 5, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0});
        vecs.push_back('{7'b0100011, 3'b011, 4'b0000, 0, 0, 4, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0});
        vecs.push_back('{7'b0100011, 3'b011, 4'b0000, 15, 0, 19, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b0});
        vecs.push_back('{7'b0100011, 3'b011, 4'b0000, 99, 100, 0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b1});
        vecs.push_back('{7'b0000011, 3'b011, 4'b0000, 99, 4, 0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1});
        vecs.push_back('{7'b1111111, 3'b000, 4'b0000, 0, 10, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0});

        legalOps = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                     7'b1100011, 7'b0110111, 7'b1101111};

        doReset();

        // Reset in the middle of EXEC: outputs drop at once, then IDLE, then FETCH.
        runInstr("rst_mid", 7'b0110011, 3'b000, 4'b0000, 0, 0, 3);
        #1 rst = 1'b1;
        #1 checkOutput("rst_mid_exec", 13'd0, CARE_ALL);
        @(posedge clk);
        #1 rst = 1'b0;
        #3 checkOutput("rst_mid_idle", 13'd0, CARE_ALL);

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            runInstr($sformatf("vec%0d", k), v.op, v.f3, v.fl, v.waits, v.hold, 1000);
            checkVal($sformatf("vec%0d len", k), obsLen, v.len);
            if (!(v.halt && !v.errx)) begin
                checkVal($sformatf("vec%0d alu_cmd", k), int'(obsCmd), int'(v.cmd));
                checkVal($sformatf("vec%0d alu_src", k), int'(obsAsrc), int'(v.asrc));
            end
            if (v.len != 0)
                checkVal($sformatf("vec%0d pc_src", k), int'(obsPsrc), int'(v.psrc));
            checkVal($sformatf("vec%0d rf_we", k), int'(obsRfWe), int'(v.rfwe));
            if (v.rfwe)
                checkVal($sformatf("vec%0d rf_src", k), int'(obsRsrc), int'(v.rsrc));
            checkVal($sformatf("vec%0d d_mem_we cycles", k), obsDwe, v.dwe);
            checkVal($sformatf("vec%0d halted", k), int'(obsHalt), int'(v.halt));
            checkVal($sformatf("vec%0d err", k), int'(obsErr), int'(v.errx));
            if (v.halt) doReset();
        end

        for (int n = 0; n < 80; n++) begin
            if (($urandom % 16) == 0)
                op = 7'($urandom);
            else
                op = legalOps[$urandom_range(0, 6)];
            waits = (($urandom % 20) == 0) ? 99 : int'($urandom_range(0, 4));
            runInstr($sformatf("rnd%0d", n), op, 3'($urandom), 4'($urandom), waits, 3, 1000);
            if (expQ[expQ.size() - 1].exp[1]) doReset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
